mand_frame_dispatcher: RTL and testbench
========================================

Name: mand_frame_dispatcher

Overview:
Initiator side of the Mandelbrot solver interface. On start, sweeps a WIDTH x HEIGHT pixel grid in raster order and maps each pixel to a complex c in signed 4.23 fixed point (27 bits). For each pixel it loads one solver (load pulse plus held c), waits for the solver's ready flag, and forwards {x, y, iteration result} downstream on a valid/ready stream toward the frame-buffer writer. One pixel is in flight at a time.

Parameters:
WIDTH, 640, pixels per row
HEIGHT, 480, rows per frame
X_BITS, 10, width of pixel x index
Y_BITS, 9, width of pixel y index

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  begin a frame; sampled only in IDLE
x_min  in  27  signed 4.23 real coordinate of column 0; latched on accepted start
y_max  in  27  signed 4.23 imaginary coordinate of row 0; latched on accepted start
step  in  27  signed 4.23 pixel pitch (both axes); latched on accepted start
solver_reset  out  1  solver load/restart; high loads c into the solver
solver_c_re  out  27  signed c real part to solver
solver_c_im  out  27  signed c imaginary part to solver
solver_out_ready  in  1  solver result valid
solver_out  in  32  signed iteration count; -1 = converged
pix_valid  out  1  result stream valid
pix_ready  in  1  downstream accepts result
pix_x  out  X_BITS  pixel column of result
pix_y  out  Y_BITS  pixel row of result
pix_iter  out  32  signed copy of solver_out
busy  out  1  high from accepted start until the frame completes
done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- States: IDLE, LOAD, RUN, EMIT. All outputs registered.
- Reset (any state): state=IDLE; solver_reset=1; solver_c_re=0; solver_c_im=0; pix_valid=0; pix_x=0; pix_y=0; pix_iter=0; busy=0; done=0; x/y counters=0. Reset mid-frame aborts the frame; no pix_valid or done follows.
- solver_reset=1 in IDLE and LOAD, 0 in RUN and EMIT. The solver is held in reset while idle.
- IDLE: if start=1, latch x_min/y_max/step, set solver_c_re=x_min, solver_c_im=y_max, x=y=0, busy=1, go to LOAD. Otherwise stay.
- LOAD: exactly 1 cycle. solver_reset=1 while c is stable. Next state is RUN.
- RUN: solver_c_re/solver_c_im held constant. In the first RUN cycle solver_out_ready is already 0, because the solver clears it on reset. When solver_out_ready=1: capture pix_iter=solver_out, pix_x=x, pix_y=y, set pix_valid=1, go to EMIT. No timeout; the solver guarantees termination.
- EMIT: pix_* held stable while pix_valid=1 and pix_ready=0. On pix_valid and pix_ready both high: pix_valid=0, then one of the following.
  - Last pixel (x=WIDTH-1, y=HEIGHT-1): busy=0, done=1 for one cycle, go to IDLE.
  - End of row (x=WIDTH-1): x=0, y+=1, solver_c_re=latched x_min, solver_c_im-=step, go to LOAD.
  - Otherwise: x+=1, solver_c_re+=step, go to LOAD.
- Coordinate arithmetic: 27-bit two's-complement add/sub, wrapping, no saturation. The solver's overflow check classifies out-of-range points.
- Throughput per pixel: 1 (LOAD) + solver latency + 1 or more (EMIT) cycles.
- start outside IDLE is ignored. Changes to x_min/y_max/step during a frame have no effect.
- done and the IDLE transition occur in the same edge as the last handshake. start may be accepted the very next cycle.

Test Plan:
- WIDTH=4, HEIGHT=2, x_min=-2.0 (27'h7000000), y_max=1.0 (27'h0800000), step=0.5 (27'h0400000), pix_ready=1, behavioural solver with fixed 5-cycle latency.
  - Required: 8 results in order (0,0)..(3,0),(0,1)..(3,1).
  - Solver c sequence: re -2.0,-1.5,-1.0,-0.5 at im 1.0, then the same re at im 0.5.
  - done pulses once; busy falls in the same cycle.
- Real solver, CONVERGENCE_ITER=100, x_min=0, y_max=0, step=0, 1x1 frame.
  - Required: pix_iter=-1, pix_x=0, pix_y=0.
  - Point c=(2.0,0) in a 1x1 frame: pix_iter=1 (diverges after first iterate).
- Backpressure: hold pix_ready=0 for 10 cycles at first result.
  - Required: pix_valid, pix_x, pix_y and pix_iter stable for all 10 cycles.
  - solver_reset stays 0 and c is unchanged throughout.
  - After the handshake, next LOAD in the following cycle.
- Reset asserted in RUN mid-frame.
  - Required: the next cycle shows solver_reset=1, pix_valid=0, busy=0, state IDLE.
  - A new start restarts at pixel (0,0) with newly latched coordinates.
- start pulsed while busy and x_min changed mid-frame.
  - Required: no restart; all c values derive from the originally latched x_min.
  - A start in the cycle after done is accepted.
- Check solver_reset timing.
  - Required: exactly one cycle high per pixel between frames' IDLE periods.
  - c never changes while solver_reset=0 within a pixel.

Source files
------------

// File: rtl/mand_frame_dispatcher.sv
// ----------------------------------------------------------------------------
// mand_frame_dispatcher
//
// Initiator side of the Mandelbrot solver interface. A start request sweeps a
// WIDTH x HEIGHT pixel grid in raster order. Each pixel is mapped to a complex
// point c in signed 4.23 fixed point. The block loads that point into a
// single solver and waits for the solver's result. It then forwards
// {x, y, iteration count} downstream on a valid/ready stream. Only one pixel
// is in flight at any time.
//
// Ports:
//   clock            system clock
//   reset            synchronous, active-high
//   start            begin a frame (only honoured while idle)
//   x_min            real coordinate of column 0, latched on accepted start
//   y_max            imaginary coordinate of row 0, latched on accepted start
//   step             pixel pitch on both axes, latched on accepted start
//   solver_reset     high loads/holds the solver with the current c
//   solver_c_re      c real part to the solver
//   solver_c_im      c imaginary part to the solver
//   solver_out_ready solver result valid
//   solver_out       solver iteration count (-1 = converged)
//   pix_valid        result stream valid
//   pix_ready        downstream accepts the result
//   pix_x, pix_y     pixel coordinates of the presented result
//   pix_iter         iteration count of the presented result
//   busy             high from accepted start until the frame completes
//   done             one-cycle pulse after the last pixel is accepted
// ----------------------------------------------------------------------------
module mand_frame_dispatcher #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int X_BITS = 10,
    parameter int Y_BITS = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [26:0]       x_min,
    input  logic [26:0]       y_max,
    input  logic [26:0]       step,
    output logic              solver_reset,
    output logic [26:0]       solver_c_re,
    output logic [26:0]       solver_c_im,
    input  logic              solver_out_ready,
    input  logic [31:0]       solver_out,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [X_BITS-1:0] pix_x,
    output logic [Y_BITS-1:0] pix_y,
    output logic [31:0]       pix_iter,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        EMIT
    } state_t;

    localparam logic [X_BITS-1:0] LAST_X = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0] LAST_Y = Y_BITS'(HEIGHT - 1);

    state_t            r_state;
    logic [26:0]       r_xMin;
    logic [26:0]       r_step;
    logic [X_BITS-1:0] r_x;
    logic [Y_BITS-1:0] r_y;
    logic              r_solverReset;
    logic [26:0]       r_cRe;
    logic [26:0]       r_cIm;
    logic              r_pixValid;
    logic [X_BITS-1:0] r_pixX;
    logic [Y_BITS-1:0] r_pixY;
    logic [31:0]       r_pixIter;
    logic              r_busy;
    logic              r_done;

    // Sequencer. Every output is a register, so the solver and the downstream
    // writer never see combinational glitches. solver_reset is raised on
    // every transition into IDLE or LOAD and dropped on entry to RUN. The
    // solver therefore sees exactly one load cycle per pixel with c already
    // stable. c is stepped incrementally with wrapping 27-bit arithmetic.
    // Out-of-range points are left for the solver to classify.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_xMin        <= '0;
            r_step        <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_solverReset <= 1'b1;
            r_cRe         <= '0;
            r_cIm         <= '0;
            r_pixValid    <= 1'b0;
            r_pixX        <= '0;
            r_pixY        <= '0;
            r_pixIter     <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_xMin  <= x_min;
                        r_step  <= step;
                        r_cRe   <= x_min;
                        r_cIm   <= y_max;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_solverReset <= 1'b0;
                    r_state       <= RUN;
                end
                RUN: begin
                    if (solver_out_ready) begin
                        r_pixIter  <= solver_out;
                        r_pixX     <= r_x;
                        r_pixY     <= r_y;
                        r_pixValid <= 1'b1;
                        r_state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (r_pixValid && pix_ready) begin
                        r_pixValid    <= 1'b0;
                        r_solverReset <= 1'b1;
                        if (r_x == LAST_X && r_y == LAST_Y) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else if (r_x == LAST_X) begin
                            r_x     <= '0;
                            r_y     <= r_y + 1'b1;
                            r_cRe   <= r_xMin;
                            r_cIm   <= r_cIm - r_step;
                            r_state <= LOAD;
                        end else begin
                            r_x     <= r_x + 1'b1;
                            r_cRe   <= r_cRe + r_step;
                            r_state <= LOAD;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign solver_reset = r_solverReset;
    assign solver_c_re  = r_cRe;
    assign solver_c_im  = r_cIm;
    assign pix_valid    = r_pixValid;
    assign pix_x        = r_pixX;
    assign pix_y        = r_pixY;
    assign pix_iter     = r_pixIter;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_mand_frame_dispatcher.sv
// ----------------------------------------------------------------------------
// tb_mand_frame_dispatcher
//
// Drives a 4x2 frame dispatcher against a behavioural fixed-latency solver.
// The expected pixel results and the expected solver c sequence are queued
// when each frame is started. A monitor pops and compares them as the DUT
// presents loads and results.
// ----------------------------------------------------------------------------
module tb_mand_frame_dispatcher;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int LAT = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [26:0] xMin  = '0;
    logic [26:0] yMax  = '0;
    logic [26:0] step  = '0;
    logic        solverReset;
    logic [26:0] cRe;
    logic [26:0] cIm;
    logic        solverOutReady;
    logic [31:0] solverOut;
    logic        pixValid;
    logic        pixReady = 1'b1;
    logic [9:0]  pixX;
    logic [8:0]  pixY;
    logic [31:0] pixIter;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [31:0] iter;
    } pix_t;

    typedef struct {
        logic [26:0] re;
        logic [26:0] im;
    } c_t;

    pix_t pixQ[$];
    c_t   cQ[$];

    int          doneCount  = 0;
    int          loadCycles = 0;
    logic        prevDone   = 1'b0;
    logic        afterHs    = 1'b0;
    logic [26:0] snapRe     = '0;
    logic [26:0] snapIm     = '0;

    always #5 clock = ~clock;

    mand_frame_dispatcher #(
        .WIDTH (W),
        .HEIGHT(H),
        .X_BITS(10),
        .Y_BITS(9)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .x_min           (xMin),
        .y_max           (yMax),
        .step            (step),
        .solver_reset    (solverReset),
        .solver_c_re     (cRe),
        .solver_c_im     (cIm),
        .solver_out_ready(solverOutReady),
        .solver_out      (solverOut),
        .pix_valid       (pixValid),
        .pix_ready       (pixReady),
        .pix_x           (pixX),
        .pix_y           (pixY),
        .pix_iter        (pixIter),
        .busy            (busy),
        .done            (done)
    );

    // Stand-in iteration result: any function of c will do, as long as a
    // wrong c shows up as a wrong result.
    function automatic logic [31:0] iterOf(input logic [26:0] re, input logic [26:0] im);
        logic [31:0] sRe;
        logic [31:0] sIm;
        sRe = {{5{re[26]}}, re};
        sIm = {{5{im[26]}}, im};
        return sRe - (sIm * 32'd3);
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural solver: captures c while held in reset. It raises ready
    // LAT cycles after release and keeps it high until the next reset.
    logic        sReady = 1'b0;
    logic [31:0] sOut   = '0;
    logic [26:0] sRe    = '0;
    logic [26:0] sIm    = '0;
    int          sCnt   = 0;

    always @(posedge clock) begin
        if (solverReset === 1'b1) begin
            sReady <= 1'b0;
            sCnt   <= 0;
            sRe    <= cRe;
            sIm    <= cIm;
        end else if (!sReady) begin
            if (sCnt == LAT - 1) begin
                sReady <= 1'b1;
                sOut   <= iterOf(sRe, sIm);
            end
            sCnt <= sCnt + 1;
        end
    end

    assign solverOutReady = sReady;
    assign solverOut      = sOut;

    // Monitor: checks each solver load against the expected c sequence and
    // checks that c holds while the solver runs. It compares each accepted
    // result with the scoreboard. It also checks the done pulse shape and
    // the number of load cycles in each frame.
    always @(negedge clock) begin
        pix_t e;
        c_t   ce;
        if (afterHs) begin
            checkOutput("load_after_hs", 128'(solverReset), 128'(1'b1));
            afterHs = 1'b0;
        end
        if (busy && solverReset) begin
            loadCycles++;
            snapRe = cRe;
            snapIm = cIm;
            if (cQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_load actual=%0h/%0h required=none", cRe, cIm);
            end else begin
                ce = cQ.pop_front();
                checkOutput("load_c_re", 128'(cRe), 128'(ce.re));
                checkOutput("load_c_im", 128'(cIm), 128'(ce.im));
            end
        end else if (busy) begin
            checkOutput("c_stable", {cRe, cIm}, {snapRe, snapIm});
        end
        if (pixValid && pixReady) begin
            afterHs = 1'b1;
            if (pixQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_pix actual=(%0d,%0d) required=none", pixX, pixY);
            end else begin
                e = pixQ.pop_front();
                checkOutput("pix_xy_iter", {pixX, pixY, pixIter}, {e.x, e.y, e.iter});
            end
        end
        if (prevDone) checkOutput("done_single", 128'(done), 128'(1'b0));
        if (done) begin
            doneCount++;
            checkOutput("busy_at_done", 128'(busy), 128'(1'b0));
            checkOutput("loads_per_frame", 128'(loadCycles), 128'(W * H));
        end
        prevDone = done;
        if (!busy) loadCycles = 0;
    end

    // Queue expected c and results for a frame using x_min + x*step and
    // y_max - y*step, wrapping at 27 bits.
    task automatic pushFrame(input logic [26:0] xm, input logic [26:0] ym, input logic [26:0] st);
        logic [26:0] re;
        logic [26:0] im;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                re = xm + 27'(x) * st;
                im = ym - 27'(y) * st;
                cQ.push_back('{re: re, im: im});
                pixQ.push_back('{x: 10'(x), y: 9'(y), iter: iterOf(re, im)});
            end
        end
    endtask

    // Called on a falling edge. start is seen by the next rising edge.
    task automatic applyStimulus(input logic [26:0] xm, input logic [26:0] ym, input logic [26:0] st);
        xMin  = xm;
        yMax  = ym;
        step  = st;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < maxCycles && !seen; n++) begin
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout actual=no_done required=done");
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [26:0]  f1Re[4];
        logic [26:0]  f1Im[2];
        logic [127:0] snap;
        bit           got;
        bit           noise;

        // Hand-computed frame 1 grid: re -2.0,-1.5,-1.0,-0.5; im 1.0, 0.5.
        f1Re = '{27'h7000000, 27'h7400000, 27'h7800000, 27'h7C00000};
        f1Im = '{27'h0800000, 27'h0400000};

        // Reset state.
        repeat (3) @(negedge clock);
        checkOutput("rst_ctrl", {solverReset, pixValid, busy, done}, 4'b1000);
        checkOutput("rst_pix", {pixX, pixY, pixIter}, '0);
        checkOutput("rst_c", {cRe, cIm}, '0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("idle_no_start", {busy, solverReset}, 2'b01);

        // Frame 1: streaming with pix_ready held high.
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                cQ.push_back('{re: f1Re[x], im: f1Im[y]});
                pixQ.push_back('{x: 10'(x), y: 9'(y), iter: iterOf(f1Re[x], f1Im[y])});
            end
        end
        applyStimulus(27'h7000000, 27'h0800000, 27'h0400000);
        @(negedge clock);
        checkOutput("busy_after_start", 128'(busy), 128'(1'b1));
        waitDone(400);

        // Frame 2 starts right after done. Coordinates and start are
        // disturbed mid-frame, and the first result meets backpressure.
        pixReady = 1'b0;
        pushFrame(27'h0200000, 27'h7E00000, 27'h0100000);
        applyStimulus(27'h0200000, 27'h7E00000, 27'h0100000);
        xMin  = 27'h1234567;
        yMax  = 27'h0000000;
        step  = 27'h0000001;
        start = 1'b1;
        @(negedge clock);
        checkOutput("busy_back_to_back", 128'(busy), 128'(1'b1));
        @(posedge clock);
        #1 start = 1'b0;

        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clock);
            if (pixValid) got = 1'b1;
        end
        checkOutput("bp_first_valid", 128'(got), 128'(1'b1));
        snap = {pixValid, pixX, pixY, pixIter, solverReset, cRe, cIm};
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            checkOutput("bp_hold", {pixValid, pixX, pixY, pixIter, solverReset, cRe, cIm}, snap);
        end
        @(posedge clock);
        #1 pixReady = 1'b1;
        waitDone(400);

        // Frame 3: aborted by reset while the solver runs a later pixel.
        pushFrame(27'h0400000, 27'h0400000, 27'h0200000);
        applyStimulus(27'h0400000, 27'h0400000, 27'h0200000);
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clock);
            if (busy && !solverReset && !pixValid && pixQ.size() < W * H - 1) got = 1'b1;
        end
        checkOutput("reached_mid_run", 128'(got), 128'(1'b1));
        reset = 1'b1;
        pixQ.delete();
        cQ.delete();
        @(negedge clock);
        checkOutput("abort_state", {solverReset, pixValid, busy}, 3'b100);
        reset = 1'b0;
        noise = 1'b0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clock);
            if (pixValid || done || busy) noise = 1'b1;
        end
        checkOutput("abort_quiet", 128'(noise), 128'(1'b0));

        // Frame 4: fresh coordinates that wrap on both axes.
        pushFrame(27'h3C00000, 27'h4000000, 27'h0800000);
        applyStimulus(27'h3C00000, 27'h4000000, 27'h0800000);
        waitDone(400);

        @(negedge clock);
        checkOutput("sb_empty", 128'(pixQ.size()), 128'(0));
        checkOutput("cq_empty", 128'(cQ.size()), 128'(0));
        checkOutput("done_count", 128'(doneCount), 128'(3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
